// File: rtl/fetch_queue_if.sv
// Fetch-queue bus bundle: redirect, instruction-memory request/response and
// core-side instruction handshake grouped in one interface.
// Latency: none (wires only).
// Backpressure: carried by inst_valid/inst_ready; imem_req is held off by the fetch stage.
// master : the fetch_queue side (drives imem_req/imem_addr and the inst head).
// slave  : the core + instruction-memory side (drives redirect, imem response, inst_ready).
interface fetch_queue_if #(
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
);
   logic              redirect_valid;
   logic [ADDR_W-1:0] redirect_pc;
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_valid;
   logic [INST_W-1:0] imem_rdata;
   logic              inst_valid;
   logic              inst_ready;
   logic [INST_W-1:0] inst;
   logic [ADDR_W-1:0] inst_pc;

   modport master (
      input  redirect_valid, redirect_pc, imem_valid, imem_rdata, inst_ready,
      output imem_req, imem_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, imem_valid, imem_rdata, inst_ready,
      input  imem_req, imem_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/fetch_queue.sv
// Sequential instruction fetch from a variable-latency memory into a small PC-tagged FIFO.
// Latency: request in cycle N, response in cycle M>N, entry on inst_valid in cycle M+1.
// Backpressure: no request is issued unless a FIFO slot is free; the core pops via inst_valid/inst_ready.
// Ports: CLK, resetl (synchronous, active-high), startpc (PC loaded in reset),
//        bus (fetch_queue_if.master: redirect, imem req/resp, inst head handshake),
//        occupancy (current FIFO entry count).
module fetch_queue #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 64,
   parameter int INST_W = 32
) (
   input  logic                         CLK,
   input  logic                         resetl,
   input  logic [ADDR_W-1:0]            startpc,
   fetch_queue_if.master                bus,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   // IDLE: nothing outstanding; WAIT: response will be kept; DROP: response will be discarded
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_DROP = 2'd2;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [INST_W-1:0] inst;
   } entry_t;

   entry_t            store [DEPTH];
   entry_t            head;
   logic [1:0]        state;
   logic [ADDR_W-1:0] fetch_pc;
   logic [ADDR_W-1:0] issued_pc;
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;
   logic [CNT_W-1:0]  count;
   logic              has_slot;
   logic              issue;
   logic              push;
   logic              pop;

   // A slot is reserved at issue time; count can only fall while waiting,
   // so the eventual push can never overflow.
   assign has_slot = count < CNT_W'(DEPTH);
   assign issue    = !resetl && (state == ST_IDLE) && has_slot && !bus.redirect_valid;
   assign push     = !resetl && (state == ST_WAIT) && bus.imem_valid && !bus.redirect_valid;
   assign pop      = bus.inst_valid && bus.inst_ready && !bus.redirect_valid;

   assign bus.imem_req  = issue;
   assign bus.imem_addr = fetch_pc;

   // Outputs are forced quiet for the whole time reset is held, not just after the first edge.
   assign bus.inst_valid = !resetl && (count != '0);
   assign head           = store[rd_ptr];
   assign bus.inst       = head.inst;
   assign bus.inst_pc    = head.pc;
   assign occupancy      = resetl ? '0 : count;

   always_ff @(posedge CLK) begin
      if (resetl) begin
         fetch_pc  <= startpc;
         issued_pc <= '0;
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         state     <= ST_IDLE;
      end else if (bus.redirect_valid) begin
         // Redirect flushes everything; any same-cycle pop is ignored.
         fetch_pc <= bus.redirect_pc;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         case (state)
            ST_WAIT: state <= bus.imem_valid ? ST_IDLE : ST_DROP;
            // A response landing in the redirect cycle still retires the outstanding
            // request; remaining in DROP would wait for a response that never comes.
            ST_DROP: state <= bus.imem_valid ? ST_IDLE : ST_DROP;
            default: state <= ST_IDLE;
         endcase
      end else begin
         case (state)
            ST_IDLE: begin
               if (issue) begin
                  issued_pc <= fetch_pc;
                  state     <= ST_WAIT;
               end
            end
            ST_WAIT: begin
               if (bus.imem_valid) begin
                  fetch_pc <= issued_pc + ADDR_W'(4);
                  state    <= ST_IDLE;
               end
            end
            ST_DROP: begin
               if (bus.imem_valid) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase

         // DEPTH is a power of two, so pointer overflow is the wrap.
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Entry storage carries no reset; validity is tracked by count alone.
   always_ff @(posedge CLK) begin
      if (push) begin
         store[wr_ptr] <= '{pc: issued_pc, inst: bus.imem_rdata};
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 64;
   localparam int INST_W = 32;

   typedef struct {
      logic [63:0] pc;
      logic [31:0] inst;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetl;
   logic [63:0] startpc;
   logic [2:0]  occupancy;
   int          checks = 0;
   int          errors = 0;
   int          lat    = 1;
   exp_t        exp_q[$];

   fetch_queue_if #(.ADDR_W(ADDR_W), .INST_W(INST_W)) bus ();

   fetch_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .INST_W(INST_W)) dut (
      .CLK       (clk),
      .resetl    (resetl),
      .startpc   (startpc),
      .bus       (bus),
      .occupancy (occupancy)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
   endfunction

   // Instruction memory: one response per accepted request after 'lat' cycles.
   // Each accepted request pushes its expected entry; redirect/reset clear the scoreboard.
   initial begin
      logic        req_seen, rst_seen, pend;
      logic [63:0] addr_seen, paddr;
      int          cd;
      bus.imem_valid = 1'b0;
      bus.imem_rdata = '0;
      pend  = 1'b0;
      cd    = 0;
      paddr = '0;
      forever begin
         @(posedge clk);
         req_seen  = bus.imem_req;
         addr_seen = bus.imem_addr;
         rst_seen  = resetl;
         @(negedge clk);
         bus.imem_valid = 1'b0;
         if (rst_seen === 1'b1) begin
            pend = 1'b0;
         end else if (req_seen === 1'b1) begin
            pend  = 1'b1;
            cd    = lat;
            paddr = addr_seen;
            exp_q.push_back('{pc: addr_seen, inst: mem_word(addr_seen)});
         end
         if (pend) begin
            cd--;
            if (cd == 0) begin
               bus.imem_valid = 1'b1;
               bus.imem_rdata = mem_word(paddr);
               pend = 1'b0;
            end
         end
      end
   end

   // One cycle: drive inputs at negedge+2, sample outputs at negedge+3.
   // rdy_mode: 0 = not ready, 1 = ready, 2 = ready only when a response arrives this cycle.
   task automatic step(input int rdy_mode, input logic redir, input logic [63:0] rpc,
                       output logic popped, output logic [63:0] ppc, output logic [31:0] pinst,
                       output logic req, output logic [63:0] raddr);
      @(negedge clk);
      #2;
      bus.inst_ready     = (rdy_mode == 2) ? bus.imem_valid : (rdy_mode != 0);
      bus.redirect_valid = redir;
      bus.redirect_pc    = rpc;
      if (redir) exp_q.delete();
      #1;
      popped = bus.inst_valid && bus.inst_ready && !redir;
      ppc    = bus.inst_pc;
      pinst  = bus.inst;
      req    = bus.imem_req;
      raddr  = bus.imem_addr;
   endtask

   // Hold reset across two edges, release just after a posedge.
   task automatic do_reset(input logic [63:0] pc);
      @(negedge clk);
      #2;
      resetl             = 1'b1;
      startpc            = pc;
      bus.redirect_valid = 1'b0;
      bus.inst_ready     = 1'b0;
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      resetl = 1'b0;
   endtask

   task automatic test_reset();
      logic p, r; logic [63:0] pp, ra, exp_addr; logic [31:0] pi; exp_t e;
      int nreq, npop, first_pop;
      lat = 1; resetl = 1'b1; startpc = 64'h100;
      for (int i = 0; i < 2; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         checks++;
         if (r !== 1'b0 || bus.inst_valid !== 1'b0 || occupancy !== 3'd0) begin
            errors++;
            $display("FAIL reset_outputs: imem_req=%b inst_valid=%b occupancy=%0d, expected 0 0 0", r, bus.inst_valid, occupancy);
         end
      end
      @(posedge clk); #1; resetl = 1'b0;
      exp_addr = 64'h100; nreq = 0; npop = 0; first_pop = -1;
      for (int i = 0; i < 14; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (r) begin
            checks++;
            if (ra !== exp_addr) begin errors++; $display("FAIL seq_addr: imem_addr=%h, expected %h", ra, exp_addr); end
            exp_addr += 4; nreq++;
         end
         checks++;
         if (!(occupancy === 3'd0 || occupancy === 3'd1)) begin errors++; $display("FAIL occ_le1: occupancy=%0d, expected <=1", occupancy); end
         if (p) begin
            if (first_pop < 0) first_pop = i;
            checks++;
            if (pp !== 64'h100 + 64'(4 * npop)) begin errors++; $display("FAIL seq_pc: inst_pc=%h, expected %h", pp, 64'h100 + 64'(4 * npop)); end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
      checks++;
      if (first_pop != 2) begin errors++; $display("FAIL first_latency: first pop in cycle %0d, expected 2", first_pop); end
      checks++;
      if (nreq != 7 || npop != 6) begin errors++; $display("FAIL seq_count: requests=%0d pops=%0d, expected 7 6", nreq, npop); end
   endtask

   task automatic test_backpressure();
      logic p, r; logic [63:0] pp, ra, exp_addr; logic [31:0] pi; exp_t e;
      int nreq, npop;
      lat = 2;
      do_reset(64'h0);
      exp_addr = 64'h0; nreq = 0; npop = 0;
      for (int i = 0; i < 20; i++) begin
         step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (r) begin
            checks++;
            if (ra !== exp_addr) begin errors++; $display("FAIL fill_addr: imem_addr=%h, expected %h", ra, exp_addr); end
            exp_addr += 4; nreq++;
         end
      end
      checks++;
      if (nreq != DEPTH || occupancy !== 3'd4 || r !== 1'b0 || bus.inst_valid !== 1'b1) begin
         errors++;
         $display("FAIL full_hold: requests=%0d occupancy=%0d imem_req=%b inst_valid=%b, expected 4 4 0 1", nreq, occupancy, r, bus.inst_valid);
      end
      for (int i = 0; i < 20; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (r) begin
            checks++;
            if (ra !== exp_addr) begin errors++; $display("FAIL resume_addr: imem_addr=%h, expected %h", ra, exp_addr); end
            exp_addr += 4; nreq++;
         end
         if (p) begin
            checks++;
            if (pp !== 64'(4 * npop)) begin errors++; $display("FAIL drain_pc: inst_pc=%h, expected %h", pp, 64'(4 * npop)); end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
      checks++;
      if (npop < DEPTH || nreq <= DEPTH) begin errors++; $display("FAIL drain_count: pops=%0d requests=%0d, expected >=4 and >4", npop, nreq); end
   endtask

   task automatic test_redirect_wait();
      logic p, r; logic [63:0] pp, ra; logic [31:0] pi; exp_t e;
      int npop;
      lat = 3;
      do_reset(64'h0);
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (r !== 1'b1 || ra !== 64'h0) begin errors++; $display("FAIL rw_issue: imem_req=%b addr=%h, expected 1 0", r, ra); end
      step(1, 1'b1, 64'h400, p, pp, pi, r, ra);
      checks++;
      if (r !== 1'b0) begin errors++; $display("FAIL rw_req_in_redirect: imem_req=%b, expected 0", r); end
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0 || r !== 1'b0) begin
         errors++; $display("FAIL rw_drop_state: occupancy=%0d inst_valid=%b imem_req=%b, expected 0 0 0", occupancy, bus.inst_valid, r);
      end
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (r !== 1'b0) begin errors++; $display("FAIL rw_late_resp: imem_req=%b, expected 0", r); end
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (r !== 1'b1 || ra !== 64'h400) begin errors++; $display("FAIL rw_new_addr: imem_req=%b addr=%h, expected 1 400", r, ra); end
      npop = 0;
      for (int i = 0; i < 12; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (p) begin
            if (npop == 0) begin
               checks++;
               if (pp !== 64'h400) begin errors++; $display("FAIL rw_first_pc: inst_pc=%h, expected 400", pp); end
            end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
      checks++;
      if (npop == 0) begin errors++; $display("FAIL rw_no_pop: pops=0, expected >0"); end
   endtask

   task automatic test_redirect_coincident();
      logic p, r; logic [63:0] pp, ra; logic [31:0] pi; exp_t e;
      int n, npop;
      lat = 1;
      do_reset(64'h40);
      for (n = 0; n < 20; n++) begin
         step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (r === 1'b1 && occupancy === 3'd2) break;
      end
      checks++;
      if (n == 20) begin errors++; $display("FAIL rc_setup: occupancy=%0d, expected 2 with request pending", occupancy); end
      // Response for the pending request lands in this cycle together with redirect and ready.
      step(1, 1'b1, 64'h800, p, pp, pi, r, ra);
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0) begin
         errors++; $display("FAIL rc_flush: occupancy=%0d inst_valid=%b, expected 0 0", occupancy, bus.inst_valid);
      end
      checks++;
      if (r !== 1'b1 || ra !== 64'h800) begin errors++; $display("FAIL rc_new_addr: imem_req=%b addr=%h, expected 1 800", r, ra); end
      npop = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (p) begin
            if (npop == 0) begin
               checks++;
               if (pp !== 64'h800) begin errors++; $display("FAIL rc_first_pc: inst_pc=%h, expected 800", pp); end
            end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic p, r; logic [63:0] pp, ra; logic [31:0] pi; exp_t e;
      int n, npop;
      lat = 1;
      do_reset(64'h1000);
      for (n = 0; n < 30; n++) begin
         step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (occupancy === 3'd3) break;
      end
      checks++;
      if (n == 30) begin errors++; $display("FAIL b2b_setup: occupancy=%0d, expected 3", occupancy); end
      npop = 0;
      for (n = 0; n < 80 && npop < 20; n++) begin
         step(2, 1'b0, 64'h0, p, pp, pi, r, ra);
         checks++;
         if (occupancy !== 3'd3) begin errors++; $display("FAIL b2b_occ: occupancy=%0d, expected 3", occupancy); end
         if (p) begin
            checks++;
            if (pp !== 64'h1000 + 64'(4 * npop)) begin errors++; $display("FAIL b2b_pc: inst_pc=%h, expected %h", pp, 64'h1000 + 64'(4 * npop)); end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
      checks++;
      if (npop != 20) begin errors++; $display("FAIL b2b_count: pops=%0d, expected 20", npop); end
   endtask

   task automatic test_reset_mid_wait();
      logic p, r; logic [63:0] pp, ra; logic [31:0] pi; exp_t e;
      int n, npop;
      lat = 1;
      do_reset(64'h0);
      for (n = 0; n < 20; n++) begin
         step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (r === 1'b1 && occupancy === 3'd2) break;
      end
      checks++;
      if (n == 20) begin errors++; $display("FAIL rm_setup: occupancy=%0d, expected 2 with request pending", occupancy); end
      lat = 4;
      step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
      resetl = 1'b1; startpc = 64'h200; exp_q.delete();
      #1;
      checks++;
      if (bus.inst_valid !== 1'b0 || occupancy !== 3'd0 || bus.imem_req !== 1'b0) begin
         errors++; $display("FAIL rm_in_reset: inst_valid=%b occupancy=%0d imem_req=%b, expected 0 0 0", bus.inst_valid, occupancy, bus.imem_req);
      end
      for (int i = 0; i < 2; i++) begin
         step(0, 1'b0, 64'h0, p, pp, pi, r, ra);
         checks++;
         if (bus.inst_valid !== 1'b0 || occupancy !== 3'd0 || r !== 1'b0) begin
            errors++; $display("FAIL rm_in_reset: inst_valid=%b occupancy=%0d imem_req=%b, expected 0 0 0", bus.inst_valid, occupancy, r);
         end
      end
      lat = 1;
      @(posedge clk); #1; resetl = 1'b0;
      step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
      checks++;
      if (r !== 1'b1 || ra !== 64'h200) begin errors++; $display("FAIL rm_restart_addr: imem_req=%b addr=%h, expected 1 200", r, ra); end
      npop = 0;
      for (int i = 0; i < 10; i++) begin
         step(1, 1'b0, 64'h0, p, pp, pi, r, ra);
         if (p) begin
            if (npop == 0) begin
               checks++;
               if (pp !== 64'h200) begin errors++; $display("FAIL rm_first_pc: inst_pc=%h, expected 200", pp); end
            end
            npop++;
            checks++;
            if (exp_q.size() == 0) begin errors++; $display("FAIL sb_pop: got pc=%h with nothing expected", pp); end
            else begin
               e = exp_q.pop_front();
               if (pp !== e.pc || pi !== e.inst) begin errors++; $display("FAIL sb_pop: got pc=%h inst=%h, expected pc=%h inst=%h", pp, pi, e.pc, e.inst); end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      resetl             = 1'b1;
      startpc            = 64'h0;
      bus.inst_ready     = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = 64'h0;
      test_reset();
      test_backpressure();
      test_redirect_wait();
      test_redirect_coincident();
      test_back_to_back();
      test_reset_mid_wait();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
